// File: rtl/jtframe_db15_joy_if.sv
// jtframe_db15_joy_if
//  Signal bundle between the DB15/SNAC serial reader and the rest of the frame.
//  Ports (seen from the reader, modport master):
//   en        in   block enable (OSD DB15 mode != Off)
//   joy_data  in   serial data from the 74HC165 chain, active-low buttons
//   joy_clk   out  shift clock to the chain
//   joy_load  out  parallel load to the chain, active-low
//   joy1      out  player 1 buttons, active-high, 12 bits
//   joy2      out  player 2 buttons, active-high, 12 bits
//   valid     out  one-cycle pulse when joy1/joy2 update
//  modport slave is the mirror image, used by whoever drives en/joy_data.
interface jtframe_db15_joy_if;
  logic        en;
  logic        joy_data;
  logic        joy_clk;
  logic        joy_load;
  logic [11:0] joy1;
  logic [11:0] joy2;
  logic        valid;

  modport master (
    input  en, joy_data,
    output joy_clk, joy_load, joy1, joy2, valid
  );

  modport slave (
    output en, joy_data,
    input  joy_clk, joy_load, joy1, joy2, valid
  );
endinterface

// File: rtl/jtframe_db15_joy.sv
// jtframe_db15_joy
//  Serial reader for the MiSTer DB15/SNAC joystick adapter (74HC165 chain).
//  Generates the load/shift strobes, samples the chain and publishes two
//  active-high 12-bit player words, updated atomically with a valid pulse.
//  Ports:
//   clk  in  system clock
//   rst  in  asynchronous reset, active-high
//   bus  jtframe_db15_joy_if.master (en, joy_data in; joy_clk, joy_load,
//        joy1, joy2, valid out)
//  Parameters:
//   CLKDIV  clk cycles per half-period of joy_clk (one tick), >= 4
//   NBITS   bits shifted per frame, fixed at 24 (two 12-bit players)
//   GAP     idle ticks between the end of a frame and the next load
module jtframe_db15_joy #(
  parameter int CLKDIV = 48,
  parameter int NBITS  = 24,
  parameter int GAP    = 64
) (
  input logic                  clk,
  input logic                  rst,
  jtframe_db15_joy_if.master   bus
);

  localparam int TW = $clog2(CLKDIV);
  localparam int BW = $clog2(NBITS);
  localparam int GW = $clog2(GAP + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT_LO,
    SHIFT_HI,
    GAP_WAIT
  } state_t;

  state_t             state;
  logic [TW-1:0]      tcnt;
  logic [BW-1:0]      bitcnt;
  logic [GW-1:0]      gapcnt;
  logic [NBITS-1:0]   raw;
  logic               data_meta;
  logic               data_sync;
  logic               joy_clk;
  logic               joy_load;
  logic [11:0]        joy1;
  logic [11:0]        joy2;
  logic               valid;
  logic               tick;

  assign tick = (tcnt == TW'(CLKDIV - 1));

  assign bus.joy_clk  = joy_clk;
  assign bus.joy_load = joy_load;
  assign bus.joy1     = joy1;
  assign bus.joy2     = joy2;
  assign bus.valid    = valid;

  // Single FSM; strobes and player words are registered alongside the state
  // so they change on the same edge as the state that owns them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      tcnt      <= '0;
      bitcnt    <= '0;
      gapcnt    <= '0;
      raw       <= '0;
      data_meta <= 1'b1;
      data_sync <= 1'b1;
      joy_clk   <= 1'b0;
      joy_load  <= 1'b1;
      joy1      <= '0;
      joy2      <= '0;
      valid     <= 1'b0;
    end else begin
      // joy_data is asynchronous to clk
      data_meta <= bus.joy_data;
      data_sync <= data_meta;
      valid     <= 1'b0;

      if (!bus.en) begin
        // Disabling abandons any frame in progress and blanks the outputs.
        state    <= IDLE;
        tcnt     <= '0;
        bitcnt   <= '0;
        gapcnt   <= '0;
        raw      <= '0;
        joy_clk  <= 1'b0;
        joy_load <= 1'b1;
        joy1     <= '0;
        joy2     <= '0;
      end else begin
        // Every state lasts a whole number of ticks, so tcnt is 0 on entry.
        tcnt <= (state == IDLE || tick) ? '0 : tcnt + TW'(1);

        case (state)
          IDLE: begin
            state    <= LOAD;
            joy_load <= 1'b0;
            joy_clk  <= 1'b0;
          end

          LOAD: begin
            if (tick) begin
              state    <= SHIFT_LO;
              bitcnt   <= '0;
              joy_load <= 1'b1;
            end
          end

          SHIFT_LO: begin
            // Sample at the end of the low phase: the bit has been stable
            // for a full tick, well past the synchronizer latency.
            if (tick) begin
              raw[bitcnt] <= data_sync;
              state       <= SHIFT_HI;
              joy_clk     <= 1'b1;
            end
          end

          SHIFT_HI: begin
            if (tick) begin
              joy_clk <= 1'b0;
              if (bitcnt == BW'(NBITS - 1)) begin
                joy1   <= ~raw[11:0];
                joy2   <= ~raw[23:12];
                valid  <= 1'b1;
                gapcnt <= '0;
                state  <= GAP_WAIT;
              end else begin
                bitcnt <= bitcnt + BW'(1);
                state  <= SHIFT_LO;
              end
            end
          end

          GAP_WAIT: begin
            if (tick) begin
              if (gapcnt == GW'(GAP - 1)) begin
                gapcnt   <= '0;
                state    <= LOAD;
                joy_load <= 1'b0;
              end else begin
                gapcnt <= gapcnt + GW'(1);
              end
            end
          end

          default: begin
            state    <= IDLE;
            joy_clk  <= 1'b0;
            joy_load <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jtframe_db15_joy.sv
// tb_jtframe_db15_joy
//  Directed bench for jtframe_db15_joy with CLKDIV=4, GAP=8 and a clocked
//  74HC165 chain model (parallel load while joy_load is low, shift towards
//  QH on each joy_clk rising edge, serial input tied high).
module tb_jtframe_db15_joy;

  logic clk;
  logic rst;
  logic [23:0] pattern;
  logic [23:0] sr;
  logic        clk_prev;

  int tests_run;
  int tests_failed;

  jtframe_db15_joy_if bus ();

  jtframe_db15_joy #(
    .CLKDIV (4),
    .NBITS  (24),
    .GAP    (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 165 chain model
  initial begin
    sr       = '1;
    clk_prev = 1'b0;
  end
  always @(posedge clk) begin
    if (!bus.joy_load)
      sr <= pattern;
    else if (bus.joy_clk && !clk_prev)
      sr <= {1'b1, sr[23:1]};
    clk_prev <= bus.joy_clk;
  end
  assign bus.joy_data = sr[0];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = %0h", tag, got);
    end
  endtask

  // Runs until the next valid pulse, measuring frame length and joy_clk edges.
  task automatic run_frame(output int cycles, output int rises, output int min_sp,
                           output int max_sp, output bit held);
    logic        prev;
    int          last_rise;
    logic [11:0] h1, h2;
    cycles    = 0;
    rises     = 0;
    min_sp    = 9999;
    max_sp    = 0;
    held      = 1'b1;
    prev      = bus.joy_clk;
    last_rise = -1;
    h1        = bus.joy1;
    h2        = bus.joy2;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      #1;
      cycles++;
      if (bus.joy_clk && !prev) begin
        rises++;
        if (last_rise >= 0) begin
          if (cycles - last_rise < min_sp) min_sp = cycles - last_rise;
          if (cycles - last_rise > max_sp) max_sp = cycles - last_rise;
        end
        last_rise = cycles;
      end
      prev = bus.joy_clk;
      if (bus.valid) return;
      if (bus.joy1 !== h1 || bus.joy2 !== h2) held = 1'b0;
    end
    check("frame_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int  cyc, rises, min_sp, max_sp, cnt;
    bit  held;
    logic prev;

    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    bus.en       = 1'b0;
    pattern      = 24'h000000;

    repeat (3) @(posedge clk);
    #1;
    check("rst_joy_clk",  {31'd0, bus.joy_clk},  32'd0);
    check("rst_joy_load", {31'd0, bus.joy_load}, 32'd1);
    check("rst_joy1",     {20'd0, bus.joy1},     32'd0);
    check("rst_joy2",     {20'd0, bus.joy2},     32'd0);
    check("rst_valid",    {31'd0, bus.valid},    32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // All buttons pressed: first valid 4*(1+48)=196 cycles after load starts
    bus.en = 1'b1;
    @(posedge clk);
    #1;
    check("load_start", {31'd0, bus.joy_load}, 32'd0);
    run_frame(cyc, rises, min_sp, max_sp, held);
    check("first_valid_latency", cyc, 32'd196);
    check("all_joy1", {20'd0, bus.joy1}, 32'hFFF);
    check("all_joy2", {20'd0, bus.joy2}, 32'hFFF);
    @(posedge clk);
    #1;
    check("valid_one_cycle", {31'd0, bus.valid}, 32'd0);

    // Only raw[0] and raw[12] pressed; pattern changes during the gap
    pattern = 24'hFFEFFE;
    run_frame(cyc, rises, min_sp, max_sp, held);
    check("frame_period", cyc, 32'd227);
    check("bit_joy1", {20'd0, bus.joy1}, 32'h001);
    check("bit_joy2", {20'd0, bus.joy2}, 32'h001);
    check("clk_rises", rises, 32'd24);
    check("rise_min_spacing", min_sp, 32'd8);
    check("rise_max_spacing", max_sp, 32'd8);
    check("held_until_valid", {31'd0, held}, 32'd1);

    // joy_data floating high for 3 frames
    pattern = 24'hFFFFFF;
    for (int f = 0; f < 3; f++) begin
      run_frame(cyc, rises, min_sp, max_sp, held);
      check($sformatf("high_period%0d", f), cyc, 32'd228);
      check($sformatf("high_joy1_%0d", f), {20'd0, bus.joy1}, 32'd0);
      check($sformatf("high_joy2_%0d", f), {20'd0, bus.joy2}, 32'd0);
    end

    // Mixed pattern, then drop en after 10 shifted bits
    pattern = 24'h5A3C96;
    run_frame(cyc, rises, min_sp, max_sp, held);
    check("mix_joy1", {20'd0, bus.joy1}, 32'h369);
    check("mix_joy2", {20'd0, bus.joy2}, 32'hA5C);
    rises = 0;
    prev  = bus.joy_clk;
    for (int i = 0; i < 1000 && rises < 10; i++) begin
      @(posedge clk);
      #1;
      if (bus.joy_clk && !prev) rises++;
      prev = bus.joy_clk;
    end
    check("ten_rises", rises, 32'd10);
    bus.en = 1'b0;
    @(posedge clk);
    #1;
    check("drop_joy_clk",  {31'd0, bus.joy_clk},  32'd0);
    check("drop_joy_load", {31'd0, bus.joy_load}, 32'd1);
    check("drop_joy1",     {20'd0, bus.joy1},     32'd0);
    check("drop_joy2",     {20'd0, bus.joy2},     32'd0);
    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      if (bus.valid || !bus.joy_load || bus.joy_clk) cnt++;
    end
    check("idle_quiet", cnt, 32'd0);

    // Re-enable: joy_load low for one tick, then a full correct frame
    bus.en = 1'b1;
    @(posedge clk);
    #1;
    check("reload_start", {31'd0, bus.joy_load}, 32'd0);
    cnt = 1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (bus.joy_load) break;
      cnt++;
    end
    check("reload_low_cycles", cnt, 32'd4);
    run_frame(cyc, rises, min_sp, max_sp, held);
    check("reen_latency", cyc, 32'd192);
    check("reen_joy1", {20'd0, bus.joy1}, 32'h369);
    check("reen_joy2", {20'd0, bus.joy2}, 32'hA5C);

    // Asynchronous reset during SHIFT_HI
    cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      #1;
      if (bus.joy_clk) begin
        cnt = 1;
        break;
      end
    end
    check("found_shift_hi", cnt, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_joy_clk",  {31'd0, bus.joy_clk},  32'd0);
    check("arst_joy_load", {31'd0, bus.joy_load}, 32'd1);
    check("arst_joy1",     {20'd0, bus.joy1},     32'd0);
    check("arst_joy2",     {20'd0, bus.joy2},     32'd0);
    check("arst_valid",    {31'd0, bus.valid},    32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_load", {31'd0, bus.joy_load}, 32'd0);
    check("post_rst_clk",  {31'd0, bus.joy_clk},  32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
